// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory unit: FSM state encoding,
// data width and the word-index width derived from memory depth.
package dm_pkg;

   localparam int WORD_W   = 32;
   localparam int BYTE_LSB = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } dm_state_t;

   // Width of the word index for a power-of-two number of words.
   function automatic int word_idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port data RAM: synchronous write, combinational read, DEPTH x WORD_W.
module dm_ram
   import dm_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = word_idx_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/data_memory_unit.sv
// Multi-cycle data-memory responder: posted single-cycle stores and loads
// that complete LATENCY cycles after acceptance, signalled by DMdone.
module data_memory_unit
   import dm_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              is_Ld,
   input  logic              is_St,
   input  logic              stop,
   input  logic [31:0]       addr,
   input  logic [31:0]       store_data,
   output logic [31:0]       load_data,
   output logic              DMdone,
   output logic              busy,
   output dm_state_t         state_dbg
);

   localparam int AW = word_idx_w(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   // Handshake: is_Ld is a request that must stay high until DMdone; dropping
   // it mid-access cancels the load. DMdone is a one-cycle valid that is
   // stretched while stop holds the pipeline. Stores need no response.

   dm_state_t         state, state_next;
   logic [CW-1:0]     cnt, cnt_next;
   logic [AW-1:0]     lat_idx, lat_idx_next;
   logic [WORD_W-1:0] ld_next;
   logic [AW-1:0]     cur_idx, ram_idx;
   logic [WORD_W-1:0] ram_rdata;
   logic              ram_we;
   logic              unused_addr_bits;

   assign cur_idx          = addr[AW+1:BYTE_LSB];
   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_idx   <= '0;
         load_data <= '0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         lat_idx   <= lat_idx_next;
         load_data <= ld_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      lat_idx_next = lat_idx;
      ld_next      = load_data;
      ram_we       = 1'b0;
      // The RAM port follows the live address only while a request can be taken.
      ram_idx      = (state == IDLE) ? cur_idx : lat_idx;
      case (state)
         IDLE: begin
            if (is_Ld && !stop) begin
               lat_idx_next = cur_idx;
               cnt_next     = CNT_INIT;
               if (LATENCY == 1) begin
                  state_next = DONE;
                  ld_next    = ram_rdata;
               end else begin
                  state_next = ACCESS;
               end
            end else if (is_St && !stop && !reset) begin
               ram_we = 1'b1;
            end
         end
         ACCESS: begin
            if (!is_Ld) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state_next = DONE;
                  ld_next    = ram_rdata;
               end
            end
         end
         DONE: begin
            if (!stop) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   dm_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .idx   (ram_idx),
      .wdata (store_data),
      .rdata (ram_rdata)
   );

   assign DMdone    = (state == DONE);
   assign busy      = (state == ACCESS);
   assign state_dbg = state;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: a LATENCY=4/DEPTH=1024 and a LATENCY=1/DEPTH=16
// instance share one stimulus stream and are checked against a timeline model.
module tb_data_memory_unit;
   import dm_pkg::*;

   localparam int LAT [2] = '{4, 1};
   localparam int DEP [2] = '{1024, 16};

   logic        clk = 1'b0;
   logic        reset;
   logic        is_ld, is_st, stop;
   logic [31:0] addr, sdata;
   logic [31:0] ld0, ld1;
   logic        done0, done1, busy0, busy1;
   dm_state_t   st0, st1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_memory_unit #(.DEPTH(1024), .LATENCY(4)) dut0 (
      .clk(clk), .reset(reset), .is_Ld(is_ld), .is_St(is_st), .stop(stop),
      .addr(addr), .store_data(sdata), .load_data(ld0), .DMdone(done0),
      .busy(busy0), .state_dbg(st0)
   );

   data_memory_unit #(.DEPTH(16), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .is_Ld(is_ld), .is_St(is_st), .stop(stop),
      .addr(addr), .store_data(sdata), .load_data(ld1), .DMdone(done1),
      .busy(busy1), .state_dbg(st1)
   );

   // Reference model: a load is "waiting" for m_age cycles since acceptance
   // and becomes "done" when its age reaches the configured latency.
   logic [31:0] m_mem [2][1024];
   bit          m_wait [2];
   bit          m_done [2];
   int          m_age  [2];
   int          m_idx  [2];
   logic [31:0] m_ld   [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int w;
         w = int'(addr[11:2]) % DEP[k];
         if (reset) begin
            m_wait[k] = 1'b0;
            m_done[k] = 1'b0;
            m_ld[k]   = 32'h0;
         end else if (m_done[k]) begin
            if (!stop) m_done[k] = 1'b0;
         end else if (m_wait[k]) begin
            if (!is_ld) begin
               m_wait[k] = 1'b0;
            end else begin
               m_age[k] = m_age[k] + 1;
               if (m_age[k] == LAT[k]) begin
                  m_wait[k] = 1'b0;
                  m_done[k] = 1'b1;
                  m_ld[k]   = m_mem[k][m_idx[k]];
               end
            end
         end else if (is_ld && !stop) begin
            m_idx[k] = w;
            if (LAT[k] == 1) begin
               m_done[k] = 1'b1;
               m_ld[k]   = m_mem[k][w];
            end else begin
               m_wait[k] = 1'b1;
               m_age[k]  = 1;
            end
         end else if (is_st && !stop) begin
            m_mem[k][w] = sdata;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_state(input int k);
      dm_state_t s;
      s = m_done[k] ? DONE : (m_wait[k] ? ACCESS : IDLE);
      return {30'b0, s};
   endfunction

   always @(negedge clk) begin
      chk("done0",  {31'b0, done0}, {31'b0, m_done[0]});
      chk("busy0",  {31'b0, busy0}, {31'b0, m_wait[0]});
      chk("ld0",    ld0, m_ld[0]);
      chk("state0", {30'b0, st0}, exp_state(0));
      chk("done1",  {31'b0, done1}, {31'b0, m_done[1]});
      chk("busy1",  {31'b0, busy1}, {31'b0, m_wait[1]});
      chk("ld1",    ld1, m_ld[1]);
      chk("state1", {30'b0, st1}, exp_state(1));
   end

   task automatic drive(input logic ld, input logic st, input logic stp,
                        input logic [31:0] a, input logic [31:0] d);
      is_ld = ld;
      is_st = st;
      stop  = stp;
      addr  = a;
      sdata = d;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_bits(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(3);
      chk_bits("rst_done", done0, 1'b0);
      chk_bits("rst_busy", busy0, 1'b0);
      chk("rst_ld", ld0, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 0, {26'b0, i[3:0], 2'b00}, $urandom);
         tick(1);
      end

      // Store then LATENCY=4 load: busy in cycles 1-3, DMdone in cycle 4 only.
      drive(0, 1, 0, 32'h10, 32'hDEADBEEF);
      tick(1);
      drive(1, 0, 0, 32'h10, 32'h0);
      tick(1);
      chk_bits("d1_c1_done", done0, 1'b0);
      chk_bits("d1_c1_busy", busy0, 1'b1);
      chk_bits("d1_l1_done", done1, 1'b1);
      chk("d1_l1_ld", ld1, 32'hDEADBEEF);
      tick(1);
      chk_bits("d1_c2_busy", busy0, 1'b1);
      tick(1);
      chk_bits("d1_c3_busy", busy0, 1'b1);
      chk_bits("d1_c3_done", done0, 1'b0);
      tick(1);
      chk_bits("d1_c4_done", done0, 1'b1);
      chk_bits("d1_c4_busy", busy0, 1'b0);
      chk("d1_c4_ld", ld0, 32'hDEADBEEF);
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(1);
      chk_bits("d1_c5_done", done0, 1'b0);

      // LATENCY=1 load right after a store; the slow instance is flushed.
      drive(0, 1, 0, 32'h0, 32'h5);
      tick(1);
      drive(1, 0, 0, 32'h0, 32'h0);
      tick(1);
      chk_bits("d2_l1_done", done1, 1'b1);
      chk("d2_l1_ld", ld1, 32'h5);
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(1);
      chk_bits("d2_flush_busy", busy0, 1'b0);
      chk_bits("d2_flush_done", done0, 1'b0);
      chk("d2_flush_ld", ld0, 32'hDEADBEEF);
      tick(2);

      // Completion under stop: DMdone held for the stop cycles, no re-issue.
      drive(1, 0, 0, 32'h10, 32'h0);
      tick(3);
      drive(1, 0, 1, 32'h10, 32'h0);
      tick(1);
      chk_bits("d3_c4_done", done0, 1'b1);
      chk("d3_c4_ld", ld0, 32'hDEADBEEF);
      tick(1);
      chk_bits("d3_c5_done", done0, 1'b1);
      tick(1);
      chk_bits("d3_c6_done", done0, 1'b1);
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(1);
      chk_bits("d3_c7_done", done0, 1'b0);
      chk_bits("d3_c7_busy", busy0, 1'b0);
      tick(1);

      // Flush in the second ACCESS cycle.
      drive(0, 1, 0, 32'h20, 32'h77);
      tick(1);
      drive(1, 0, 0, 32'h20, 32'h0);
      tick(1);
      chk_bits("d4_c1_busy", busy0, 1'b1);
      tick(1);
      chk_bits("d4_c2_busy", busy0, 1'b1);
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(1);
      chk_bits("d4_c3_busy", busy0, 1'b0);
      chk_bits("d4_c3_done", done0, 1'b0);
      chk("d4_c3_ld", ld0, 32'hDEADBEEF);
      tick(1);
      chk_bits("d4_c4_done", done0, 1'b0);

      // Reset mid-ACCESS, then the stored word is still readable.
      drive(0, 1, 0, 32'h8, 32'h1234);
      tick(1);
      drive(1, 0, 0, 32'h8, 32'h0);
      tick(2);
      #2 reset = 1'b1;
      #1;
      chk_bits("d5_rst_done", done0, 1'b0);
      chk_bits("d5_rst_busy", busy0, 1'b0);
      chk("d5_rst_ld", ld0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(1);
      drive(1, 0, 0, 32'h8, 32'h0);
      tick(4);
      chk_bits("d5_done", done0, 1'b1);
      chk("d5_ld", ld0, 32'h1234);
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(2);

      // Address wrap, then load-over-store precedence at the same word.
      drive(0, 1, 0, 32'h1004, 32'hA5);
      tick(1);
      drive(1, 0, 0, 32'h4, 32'h0);
      tick(4);
      chk_bits("d6_wrap_done", done0, 1'b1);
      chk("d6_wrap_ld", ld0, 32'hA5);
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(2);
      drive(1, 1, 0, 32'h4, 32'hFF);
      tick(1);
      drive(1, 0, 0, 32'h4, 32'h0);
      tick(3);
      chk("d6_both_ld", ld0, 32'hA5);
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(2);
      drive(1, 0, 0, 32'h4, 32'h0);
      tick(4);
      chk("d6_kept_ld", ld0, 32'hA5);
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(2);

      // Randomized traffic over 16 words with random upper and byte bits.
      repeat (3000) begin
         logic ld_r;
         ld_r = m_wait[0] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
         drive(ld_r, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
               {$urandom_range(0, 32'hFFFFF), 6'b0, 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3))},
               $urandom);
         if ($urandom_range(0, 199) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end else begin
            tick(1);
         end
      end
      drive(0, 0, 0, 32'h0, 32'h0);
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
